turbo_enc_ctrl: RTL and testbench
=================================

# turbo_enc_ctrl

Frame-level controller and datapath for the rate-1/3 turbo encoder. It buffers one K-bit frame and generates QPP interleaver addresses on the fly. It sequences two identical recursive systematic convolutional (RSC) constituent encoders through the data and trellis-termination phases. It emits a (sys, p1, p2) symbol stream under valid/ready flow control, sitting between the bit source and the rate-matching/modulator stage.

## Interface
- K, 40: frame length in bits; 40..6144.
- F1, 3: QPP coefficient f1, odd.
- F2, 10: QPP coefficient f2, even.
- IDX_W, $clog2(K): index width (derived, do not override).

Ports:
- clk  in  1  sole clock, rising edge.
- clr_n  in  1  asynchronous active-low reset.
- in_bit  in  1  frame data bit.
- in_valid  in  1  in_bit valid.
- in_ready  out  1  block accepts in_bit.
- out_sys  out  1  systematic bit.
- out_p1  out  1  parity from encoder 1 (natural order).
- out_p2  out  1  parity from encoder 2 (interleaved order).
- out_tail  out  1  symbol belongs to the termination phase.
- out_last  out  1  final symbol of the frame.
- out_valid  out  1  output symbol valid.
- out_ready  in  1  downstream accepts the symbol.

## Operation
- Each RSC encoder has a state of s0 (newest), s1, s2. Per step:
  - fb = s1^s2; d = u^fb; p = d^s0^s2.
  - Next state: s0<=d, s1<=s0, s2<=s1.
  - In terminate mode, u = fb, so d = 0.
  - The polynomials are feedback 1+D²+D³ and parity 1+D+D³.
- The FSM has states LOAD, ENC, TAIL1, TAIL2.
- LOAD
  - in_ready=1; out_valid=0.
  - Each in_valid&&in_ready writes buf[wr_idx].
  - On acceptance of bit K-1, go to ENC with i=0, pi=0, g=(F1+F2) mod K, and both encoder states cleared.
- ENC
  - out_valid=1; out_sys=buf[i]; out_p1=p(enc1, u=buf[i]); out_p2=p(enc2, u=buf[pi]).
  - On handshake, both encoders step; i++; pi=(pi+g) mod K; g=(g+2·F2) mod K.
  - Use conditional subtraction only; no multipliers or dividers.
  - After the handshake at i=K-1, go to TAIL1 with tail count 0.
- TAIL1 (3 symbols)
  - Encoder 1 is in terminate mode; encoder 2 holds.
  - Outputs: out_sys=fb1, out_p1=p1, out_p2=0, out_tail=1.
- TAIL2 (3 symbols)
  - Encoder 2 is in terminate mode; encoder 1 holds.
  - Outputs: out_sys=fb2, out_p1=0, out_p2=p2, out_tail=1.
  - out_last=1 on the third symbol. Its handshake returns the FSM to LOAD with wr_idx=0.
- in_ready=0 in every state except LOAD. Input is never accepted while a frame is being encoded.
- Every encoder state is all-zero after its three tail steps.

## Timing
- Reset values:
  - state=LOAD; wr_idx, i, tail count, pi and encoder states all 0; g=(F1+F2) mod K.
  - in_ready=1; out_valid=0; out_sys, out_p1, out_p2, out_tail and out_last all 0.
- Reset asserted mid-frame aborts immediately. The partial frame is discarded and the FSM returns to LOAD.
- out_valid rises on the clock edge that accepts input bit K-1. The first symbol is visible in the following cycle.
- Output symbols are combinational from registered state and the buffer only. There is no combinational path from out_ready or in_valid to any output.
- Backpressure:
  - While out_valid&&!out_ready, every output is held stable and no state advances.
  - out_valid never drops until its handshake completes.
- Throughput is one symbol per cycle when out_ready=1. A frame takes K load cycles plus K+6 output cycles; there is no overlap between frames.
- in_valid while in_ready=0 has no effect.

## Structure
- Shared package turbo_pkg holds:
  - the state enum (LOAD, ENC, TAIL1, TAIL2);
  - TAIL_LEN=3;
  - the default QPP constants for K=40.
- Sub-module rsc_core: ports clk, clr_n, clear, step, term, u, outputs fb, p. It is instantiated twice.
- The interleaver recursion and buffer live in the top level.

## Test plan
- All-zero frame, K=40, out_ready=1 → 46 symbols, all bits 0:
  - out_tail=1 on symbols 40..45;
  - out_last=1 only on symbol 45;
  - in_ready returns to 1 on the next cycle.
- Frame with only bit 0 set:
  - symbol 0: sys=1, p1=1, p2=1;
  - symbol 1: sys=0, p1=1, p2=1;
  - all tail phases end with encoder states at 0.
- Frame with only bit 13 set → encoder 2 sees u=1 at i=1, since pi(1)=13. Check the pi sequence 0, 13, 6, 19 at i=0..3.
- Random out_ready (50%) on random frames → symbol stream identical to an out_ready=1 reference model; outputs stable during every stall.
- in_valid asserted during ENC → no bits accepted; the next frame's data starts cleanly at wr_idx=0.
- clr_n pulsed at i=20 of ENC → out_valid=0 and in_ready=1 immediately. A new frame then encodes correctly with no state carried over.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo encoder frame controller.
package turbo_pkg;

    typedef enum logic [1:0] {LOAD, ENC, TAIL1, TAIL2} state_e;

    localparam int unsigned TAIL_LEN = 3;

    // QPP interleaver defaults for the K=40 frame size.
    localparam int unsigned DEF_K  = 40;
    localparam int unsigned DEF_F1 = 3;
    localparam int unsigned DEF_F2 = 10;

endpackage

// File: rtl/rsc_core.sv
// Recursive systematic convolutional encoder: feedback 1+D^2+D^3, parity 1+D+D^3.
module rsc_core (
    input  logic clk,
    input  logic clr_n,
    input  logic clear,
    input  logic step,
    input  logic term,
    input  logic u,
    output logic fb,
    output logic p
);

    logic [2:0] s_q;  // s_q[0] is the newest stage
    logic       d;

    // Termination feeds the feedback back in, which forces the register input to zero.
    assign fb = s_q[1] ^ s_q[2];
    assign d  = term ? 1'b0 : (u ^ fb);
    assign p  = d ^ s_q[0] ^ s_q[2];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            s_q <= '0;
        end else if (clear) begin
            s_q <= '0;
        end else if (step) begin
            s_q <= {s_q[1:0], d};
        end
    end

endmodule

// File: rtl/turbo_enc_ctrl.sv
// Rate-1/3 turbo encoder controller: frame buffer, QPP address recursion, two RSC encoders
// sequenced through data and termination phases with valid/ready output flow control.
module turbo_enc_ctrl
    import turbo_pkg::*;
#(
    parameter int unsigned K     = DEF_K,
    parameter int unsigned F1    = DEF_F1,
    parameter int unsigned F2    = DEF_F2,
    parameter int unsigned IDX_W = $clog2(K)
) (
    input  logic clk,
    input  logic clr_n,
    input  logic in_bit,
    input  logic in_valid,
    output logic in_ready,
    output logic out_sys,
    output logic out_p1,
    output logic out_p2,
    output logic out_tail,
    output logic out_last,
    output logic out_valid,
    input  logic out_ready
);

    localparam logic [IDX_W-1:0] LAST      = IDX_W'(K - 1);
    localparam logic [IDX_W-1:0] G0        = IDX_W'((F1 + F2) % K);
    localparam logic [IDX_W-1:0] G_INC     = IDX_W'((2 * F2) % K);
    localparam logic [IDX_W:0]   K_EXT     = (IDX_W + 1)'(K);
    localparam logic [1:0]       TAIL_LAST = 2'(TAIL_LEN - 1);

    // Both operands are already reduced, so one conditional subtraction suffices.
    function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= K_EXT) begin
            s = s - K_EXT;
        end
        return s[IDX_W-1:0];
    endfunction

    state_e           state_q, state_d;
    logic [IDX_W-1:0] wr_q, wr_d;
    logic [IDX_W-1:0] i_q, i_d;
    logic [IDX_W-1:0] pi_q, pi_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [1:0]       tcnt_q, tcnt_d;
    logic [K-1:0]     buf_q;

    logic wr_en, enc_clear;
    logic step1, step2, term1, term2;
    logic enc1_fb, enc1_p, enc2_fb, enc2_p;

    rsc_core u_rsc1 (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (enc_clear),
        .step  (step1),
        .term  (term1),
        .u     (buf_q[i_q]),
        .fb    (enc1_fb),
        .p     (enc1_p)
    );

    rsc_core u_rsc2 (
        .clk   (clk),
        .clr_n (clr_n),
        .clear (enc_clear),
        .step  (step2),
        .term  (term2),
        .u     (buf_q[pi_q]),
        .fb    (enc2_fb),
        .p     (enc2_p)
    );

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        i_d       = i_q;
        pi_d      = pi_q;
        g_d       = g_q;
        tcnt_d    = tcnt_q;
        wr_en     = 1'b0;
        enc_clear = 1'b0;
        step1     = 1'b0;
        step2     = 1'b0;
        term1     = 1'b0;
        term2     = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_sys   = 1'b0;
        out_p1    = 1'b0;
        out_p2    = 1'b0;
        out_tail  = 1'b0;
        out_last  = 1'b0;
        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    wr_d  = wr_q + 1'b1;
                    if (wr_q == LAST) begin
                        state_d   = ENC;
                        wr_d      = '0;
                        i_d       = '0;
                        pi_d      = '0;
                        g_d       = G0;
                        enc_clear = 1'b1;
                    end
                end
            end
            ENC: begin
                out_valid = 1'b1;
                out_sys   = buf_q[i_q];
                out_p1    = enc1_p;
                out_p2    = enc2_p;
                if (out_ready) begin
                    step1 = 1'b1;
                    step2 = 1'b1;
                    i_d   = i_q + 1'b1;
                    pi_d  = mod_add(pi_q, g_q);
                    g_d   = mod_add(g_q, G_INC);
                    if (i_q == LAST) begin
                        state_d = TAIL1;
                        tcnt_d  = '0;
                    end
                end
            end
            TAIL1: begin
                term1     = 1'b1;
                out_valid = 1'b1;
                out_sys   = enc1_fb;
                out_p1    = enc1_p;
                out_tail  = 1'b1;
                if (out_ready) begin
                    step1  = 1'b1;
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TAIL_LAST) begin
                        state_d = TAIL2;
                        tcnt_d  = '0;
                    end
                end
            end
            TAIL2: begin
                term2     = 1'b1;
                out_valid = 1'b1;
                out_sys   = enc2_fb;
                out_p2    = enc2_p;
                out_tail  = 1'b1;
                out_last  = (tcnt_q == TAIL_LAST);
                if (out_ready) begin
                    step2  = 1'b1;
                    tcnt_d = tcnt_q + 1'b1;
                    if (tcnt_q == TAIL_LAST) begin
                        state_d = LOAD;
                        tcnt_d  = '0;
                        wr_d    = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= LOAD;
            wr_q    <= '0;
            i_q     <= '0;
            pi_q    <= '0;
            g_q     <= G0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            i_q     <= i_d;
            pi_q    <= pi_d;
            g_q     <= g_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Frame contents need no reset: every bit is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[wr_q] <= in_bit;
        end
    end

endmodule

// File: tb/tb_turbo_enc_ctrl.sv
// Directed and randomised bench for turbo_enc_ctrl with a scoreboard of expected symbols.
module tb_turbo_enc_ctrl;

    localparam int unsigned K  = 40;
    localparam int unsigned F1 = 3;
    localparam int unsigned F2 = 10;

    logic clk = 1'b0;
    logic clr_n;
    logic in_bit, in_valid, in_ready;
    logic out_sys, out_p1, out_p2, out_tail, out_last, out_valid, out_ready;

    int n_assert = 0;
    int n_fail   = 0;

    // {sys, p1, p2, tail, last}
    logic [4:0] exp_q[$];

    turbo_enc_ctrl #(
        .K  (K),
        .F1 (F1),
        .F2 (F2)
    ) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sys   (out_sys),
        .out_p1    (out_p1),
        .out_p2    (out_p2),
        .out_tail  (out_tail),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pi_ref(input int n);
        return (F1 * n + F2 * n * n) % K;
    endfunction

    task automatic model(input logic [K-1:0] f);
        logic [2:0] a, b;
        logic fb, d, p, fb2, d2, p2;
        a = '0;
        b = '0;
        for (int n = 0; n < K; n++) begin
            fb  = a[1] ^ a[2];
            d   = f[n] ^ fb;
            p   = d ^ a[0] ^ a[2];
            fb2 = b[1] ^ b[2];
            d2  = f[pi_ref(n)] ^ fb2;
            p2  = d2 ^ b[0] ^ b[2];
            exp_q.push_back({f[n], p, p2, 2'b00});
            a = {a[1:0], d};
            b = {b[1:0], d2};
        end
        for (int t = 0; t < 3; t++) begin
            fb = a[1] ^ a[2];
            exp_q.push_back({fb, a[0] ^ a[2], 1'b0, 1'b1, 1'b0});
            a = {a[1:0], 1'b0};
        end
        for (int t = 0; t < 3; t++) begin
            fb2 = b[1] ^ b[2];
            exp_q.push_back({fb2, 1'b0, b[0] ^ b[2], 1'b1, (t == 2)});
            b = {b[1:0], 1'b0};
        end
    endtask

    task automatic load_frame(input logic [K-1:0] f);
        check("load_ready", {out_valid, in_ready}, 2'b01);
        model(f);
        for (int n = 0; n < K; n++) begin
            in_valid = 1'b1;
            in_bit   = f[n];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("valid_rise", {out_valid, in_ready}, 2'b10);
    endtask

    task automatic drain(input bit rand_ready, input bit check_pi, input bit in_noise);
        int cyc;
        int idx;
        cyc = 0;
        idx = 0;
        while (exp_q.size() > 0) begin
            if (cyc >= 2000) begin
                check("drain_timeout", 16'd0, 16'd1);
                exp_q.delete();
                break;
            end
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_noise) begin
                in_valid = 1'b1;
                in_bit   = 1'($urandom_range(0, 1));
            end
            check("symbol", {in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last},
                  {2'b01, exp_q[0]});
            if (check_pi && idx < 4 && out_ready) begin
                check("pi_seq", 16'(dut.pi_q), 16'(pi_ref(idx)));
            end
            if (out_ready) begin
                void'(exp_q.pop_front());
                idx++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("idle_after", {in_ready, out_valid, out_tail, out_last}, 4'b1000);
        check("enc_zero", {dut.u_rsc1.s_q, dut.u_rsc2.s_q}, 16'd0);
    endtask

    function automatic logic [K-1:0] rand_frame();
        logic [K-1:0] f;
        for (int n = 0; n < K; n++) begin
            f[n] = 1'($urandom_range(0, 1));
        end
        return f;
    endfunction

    initial begin
        logic [K-1:0] f;
        clr_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #12;
        check("reset_outputs",
              {in_ready, out_valid, out_sys, out_p1, out_p2, out_tail, out_last}, 7'b1000000);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        check("reset_g", 16'(dut.g_q), 16'((F1 + F2) % K));

        f = '0;
        load_frame(f);
        drain(1'b0, 1'b0, 1'b0);

        f    = '0;
        f[0] = 1'b1;
        load_frame(f);
        check("bit0_sym0", {out_sys, out_p1, out_p2}, 3'b111);
        drain(1'b0, 1'b0, 1'b0);

        f     = '0;
        f[13] = 1'b1;
        load_frame(f);
        drain(1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 4; r++) begin
            load_frame(rand_frame());
            drain(1'b1, 1'b0, 1'b0);
        end

        load_frame(rand_frame());
        drain(1'b1, 1'b0, 1'b1);
        load_frame(rand_frame());
        drain(1'b1, 1'b0, 1'b0);

        load_frame(rand_frame());
        exp_q.delete();
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort_index", 16'(dut.i_q), 16'd20);
        clr_n = 1'b0;
        #1;
        check("abort_outputs", {in_ready, out_valid}, 2'b10);
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        load_frame(rand_frame());
        drain(1'b1, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
